cordic_fu_ctrl: RTL and testbench

- Issue/sequencing controller for the custom-0 SIN/COS instructions: SIN is funct7 0000100 with funct3 001; COS is the same funct7 with funct3 010.
- Accepts one op at a time from issue and reduces the angle to the right half-plane.
- Sequences an external iterative CORDIC core (init, then NUM_ITER step cycles), applies the quadrant sign fix, and returns a one-cycle writeback with trans_id.
- Sits in ex_stage beside the ALU/mult FUs.

---
 rtl/cordic_fu_ctrl.sv | 132 +++++++++++++
 tb/tb_cordic_fu_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_fu_ctrl.sv
// rtl/cordic_fu_ctrl.sv - SIN/COS issue controller that sequences an external iterative CORDIC core
// Optional feature macro: CORDIC_ZERO_SHORTCUT_EN (zero reduced angle bypasses the core)
module cordic_fu_ctrl #(
  parameter int unsigned  XLEN          = 64,
  parameter int unsigned  DATA_W        = 32,
  parameter int unsigned  NUM_ITER      = 16,
  parameter int unsigned  TRANS_ID_BITS = 3,
  localparam int unsigned ITER_W        = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [XLEN-1:0]          operand_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     core_init_o,
  output logic                     core_step_o,
  output logic [ITER_W-1:0]        core_iter_o,
  output logic [DATA_W-1:0]        core_angle_o,
  input  logic [DATA_W-1:0]        core_x_i,
  input  logic [DATA_W-1:0]        core_y_i,
  output logic                     result_valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_e;

  localparam logic [1:0]        OP_SIN  = 2'b01;
  localparam logic [1:0]        OP_COS  = 2'b10;
  localparam logic [DATA_W-1:0] HALF    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] QUARTER = {2'b01, {(DATA_W-2){1'b0}}};

  state_e                   state_q;
  logic [ITER_W-1:0]        iter_q;
  logic [DATA_W-1:0]        ang_q, ang_d;
  logic                     neg_q, neg_d;
  logic                     illegal_q, illegal_d;
  logic                     short_q, short_d;
  logic [1:0]               op_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic                     accept;
  logic [DATA_W-1:0]        a;
  logic [DATA_W-1:0]        res;
  logic                     unused_operand_hi;

  assign a                 = operand_i[DATA_W-1:0];
  assign unused_operand_hi = ^operand_i[XLEN-1:DATA_W];
  assign ready_o           = (state_q == IDLE) || (state_q == DONE);
  assign accept            = valid_i && ready_o;

  // Top two bits differing means |a| >= quarter turn: mirror into the right half-plane.
  always_comb begin
    neg_d     = a[DATA_W-1] ^ a[DATA_W-2];
    ang_d     = neg_d ? (HALF - a) : a;
    illegal_d = (op_i != OP_SIN) && (op_i != OP_COS);
`ifdef CORDIC_ZERO_SHORTCUT_EN
    short_d   = !illegal_d && (ang_d == '0);
`else
    short_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      ang_q     <= '0;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
      short_q   <= 1'b0;
      op_q      <= '0;
      id_q      <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            ang_q     <= ang_d;
            neg_q     <= neg_d;
            illegal_q <= illegal_d;
            short_q   <= short_d;
            op_q      <= op_i;
            id_q      <= trans_id_i;
            state_q   <= (illegal_d || short_d) ? DONE : INIT;
          end else begin
            state_q <= IDLE;
          end
        end
        INIT: begin
          state_q <= STEP;
          iter_q  <= '0;
        end
        STEP: begin
          if (iter_q == ITER_W'(NUM_ITER - 1)) begin
            state_q <= DONE;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Core results are read live in DONE, one cycle after the final step.
  always_comb begin
    res = '0;
    if (illegal_q) begin
      res = '0;
    end else if (short_q) begin
      res = (op_q == OP_COS) ? (neg_q ? (~QUARTER + 1'b1) : QUARTER) : '0;
    end else if (op_q == OP_SIN) begin
      res = core_y_i;
    end else begin
      res = neg_q ? (~core_x_i + 1'b1) : core_x_i;
    end
  end

  assign core_init_o    = (state_q == INIT);
  assign core_step_o    = (state_q == STEP);
  assign core_iter_o    = core_step_o ? iter_q : '0;
  assign core_angle_o   = ang_q;
  assign result_valid_o = (state_q == DONE) && !flush_i;
  assign result_o       = result_valid_o ? {{(XLEN-DATA_W){res[DATA_W-1]}}, res} : '0;
  assign trans_id_o     = result_valid_o ? id_q : '0;

endmodule

// File: tb/tb_cordic_fu_ctrl.sv
// tb/tb_cordic_fu_ctrl.sv - self-checking bench for cordic_fu_ctrl (honours CORDIC_ZERO_SHORTCUT_EN)
module tb_cordic_fu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [63:0] operand_i;
  logic [2:0]  trans_id_i;
  logic        core_init_o;
  logic        core_step_o;
  logic [3:0]  core_iter_o;
  logic [31:0] core_angle_o;
  logic [31:0] core_x_i;
  logic [31:0] core_y_i;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic [2:0]  trans_id_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  cordic_fu_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .op_i           (op_i),
    .operand_i      (operand_i),
    .trans_id_i     (trans_id_i),
    .core_init_o    (core_init_o),
    .core_step_o    (core_step_o),
    .core_iter_o    (core_iter_o),
    .core_angle_o   (core_angle_o),
    .core_x_i       (core_x_i),
    .core_y_i       (core_y_i),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .trans_id_o     (trans_id_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: angle folding by signed magnitude, results from trig identities.
  function automatic void model(input logic [1:0] op, input logic [63:0] operand,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] ang, output logic [63:0] res,
                                output bit full);
    int          a_s;
    bit          neg, legal, zero_short;
    logic [31:0] r;
    a_s   = $signed(operand[31:0]);
    neg   = (a_s >= 1073741824) || (a_s < -1073741824);
    ang   = neg ? (32'h8000_0000 - operand[31:0]) : operand[31:0];
    legal = (op == 2'b01) || (op == 2'b10);
`ifdef CORDIC_ZERO_SHORTCUT_EN
    zero_short = legal && (ang == 32'd0);
`else
    zero_short = 1'b0;
`endif
    full = legal && !zero_short;
    if (!legal)           r = 32'd0;
    else if (zero_short)  r = (op == 2'b10) ? (neg ? -(32'd1 << 30) : (32'd1 << 30)) : 32'd0;
    else if (op == 2'b01) r = y;
    else                  r = neg ? -x : x;
    res = {{32{r[31]}}, r};
  endfunction

  // Drives a request at the current negedge; returns positioned in its DONE cycle.
  task automatic run_op(input logic [1:0] op, input logic [63:0] operand, input logic [2:0] id,
                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ang_e;
    logic [63:0] res_e;
    bit          full;
    model(op, operand, x, y, ang_e, res_e, full);
    valid_i = 1'b1; op_i = op; operand_i = operand; trans_id_i = id;
    core_x_i = x; core_y_i = y;
    #1 check("accept_ready", ready_o, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    if (full) begin
      #1 check("init", core_init_o, 1);
      check("angle", core_angle_o, ang_e);
      check("init_no_result", result_valid_o, 0);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk_i);
        #1 check("step", core_step_o, 1);
        check("iter", core_iter_o, i);
      end
      @(negedge clk_i);
    end
    #1 check("done_valid", result_valid_o, 1);
    check("done_result", result_o, res_e);
    check("done_id", trans_id_o, id);
    check("done_init", core_init_o, 0);
    check("done_step", core_step_o, 0);
  endtask

  initial begin
    bit          rv_seen;
    logic [1:0]  rop;
    logic [63:0] ropnd;
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; op_i = '0; operand_i = '0;
    trans_id_i = '0; core_x_i = '0; core_y_i = '0;

    @(negedge clk_i);
    #1 check("rst_ready", ready_o, 1);
    check("rst_valid", result_valid_o, 0);
    check("rst_init", core_init_o, 0);
    check("rst_step", core_step_o, 0);
    check("rst_result", result_o, 0);
    check("rst_id", trans_id_o, 0);
    check("rst_angle", core_angle_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);

    run_op(2'b01, 64'h0000_0000_2000_0000, 3'd5, 32'h1234_5678, 32'h2D41_3CCD);
    @(negedge clk_i);
    run_op(2'b10, 64'h0000_0000_6000_0000, 3'd2, 32'h2D41_3CCD, 32'h0BAD_F00D);
    @(negedge clk_i);

    run_op(2'b01, 64'h0000_0000_E000_0000, 3'd1, 32'h2D41_3CCD, 32'hD2BE_C333);
    run_op(2'b10, 64'hFFFF_FFFF_A000_0000, 3'd6, 32'h2D41_3CCD, 32'h0000_0001);
    @(negedge clk_i);

    run_op(2'b10, 64'h0000_0000_8000_0000, 3'd7, 32'h4000_0000, 32'h0000_0000);
    @(negedge clk_i);
    run_op(2'b11, 64'h0000_0000_1111_1111, 3'd4, 32'h5555_5555, 32'h6666_6666);
    @(negedge clk_i);

    valid_i = 1'b1; op_i = 2'b01; operand_i = 64'h1000_0000; trans_id_i = 3'd3;
    #1 check("flush_accept", ready_o, 1);
    @(negedge clk_i); valid_i = 1'b0;
    repeat (6) @(negedge clk_i);
    flush_i = 1'b1;
    #1 check("flush_iter5", core_iter_o, 5);
    @(negedge clk_i); flush_i = 1'b0;
    #1 check("flush_ready", ready_o, 1);
    check("flush_step_off", core_step_o, 0);
    rv_seen = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      #1 if (result_valid_o) rv_seen = 1'b1;
    end
    check("flush_no_result", rv_seen, 0);

    valid_i = 1'b1; op_i = 2'b00; operand_i = 64'h0; trans_id_i = 3'd1;
    @(negedge clk_i);
    flush_i = 1'b1; valid_i = 1'b1; op_i = 2'b01; operand_i = 64'h2000_0000;
    #1 check("flush_done_valid", result_valid_o, 0);
    check("flush_done_id", trans_id_o, 0);
    @(negedge clk_i); flush_i = 1'b0; valid_i = 1'b0;
    #1 check("flush_drop_init", core_init_o, 0);
    check("flush_drop_ready", ready_o, 1);
    @(negedge clk_i);

    valid_i = 1'b1; op_i = 2'b10; operand_i = 64'h0100_0000; trans_id_i = 3'd2;
    @(negedge clk_i); valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check("arst_ready", ready_o, 1);
    check("arst_step", core_step_o, 0);
    check("arst_valid", result_valid_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    rv_seen = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      #1 if (result_valid_o) rv_seen = 1'b1;
    end
    check("arst_no_result", rv_seen, 0);
    @(negedge clk_i);

    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) rop = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      ropnd = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ropnd[31:0] = 32'h8000_0000;
        1: ropnd[31:0] = 32'h0000_0000;
        2: ropnd[31:0] = 32'h4000_0000;
        3: ropnd[31:0] = 32'hC000_0000;
        default: ;
      endcase
      run_op(rop, ropnd, 3'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 1) != 0) @(negedge clk_i);
    end
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
